// File: rtl/div_arbiter_if.sv
// Bundle of the requester-side and divider-side signals of div_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and models the divider.
interface div_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
) ();
  logic [N-1:0]         req;
  logic [N*W-1:0]       req_x;
  logic [N*W-1:0]       req_y;
  logic [N-1:0]         ack;
  logic                 resp_valid;
  logic [$clog2(N)-1:0] resp_id;
  logic [W-1:0]         resp_q;
  logic [W-1:0]         resp_r;
  logic                 resp_err;
  logic                 busy;
  logic                 div_go;
  logic [W-1:0]         div_x;
  logic [W-1:0]         div_y;
  logic                 div_done;
  logic [W-1:0]         div_q;
  logic [W-1:0]         div_r;

  modport slave (
    input  req, req_x, req_y, div_done, div_q, div_r,
    output ack, resp_valid, resp_id, resp_q, resp_r, resp_err,
           busy, div_go, div_x, div_y
  );

  modport master (
    output req, req_x, req_y, div_done, div_q, div_r,
    input  ack, resp_valid, resp_id, resp_q, resp_r, resp_err,
           busy, div_go, div_x, div_y
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin front end that shares one sequential divider between N
// requesters. Divide-by-zero is answered locally; a stuck divider is cut off
// after TIMEOUT cycles in WAIT and reported as an error.
module div_arbiter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  div_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(N);
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic [TW-1:0]    r_timer;
  logic [IDW-1:0]   r_respId;
  logic [W-1:0]     r_respQ;
  logic [W-1:0]     r_respR;
  logic             r_respErr;

  logic             w_grantValid;
  logic [IDW-1:0]   w_grantId;
  logic [W-1:0]     w_grantX;
  logic [W-1:0]     w_grantY;
  logic             w_timeout;

  // Pick the first active request at or above ptr, wrapping at N.
  always_comb begin
    int idx;
    w_grantValid = 1'b0;
    w_grantId    = '0;
    idx          = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(r_ptr) + k) % N;
      if (!w_grantValid && bus.req[idx]) begin
        w_grantValid = 1'b1;
        w_grantId    = IDW'(idx);
      end
    end
  end

  assign w_grantX  = bus.req_x[int'(w_grantId)*W +: W];
  assign w_grantY  = bus.req_y[int'(w_grantId)*W +: W];
  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; a zero divisor skips the divider entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grantValid) w_next = (w_grantY == '0) ? RESP : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (bus.div_done || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, WAIT timer, response registers and round-robin pointer.
  // Response registers only change on entry to RESP so they hold in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_timer   <= '0;
      r_respId  <= '0;
      r_respQ   <= '0;
      r_respR   <= '0;
      r_respErr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_id <= w_grantId;
            r_x  <= w_grantX;
            r_y  <= w_grantY;
            if (w_grantY == '0) begin
              r_respId  <= w_grantId;
              r_respQ   <= '1;
              r_respR   <= w_grantX;
              r_respErr <= 1'b1;
            end
          end
        end
        ISSUE: r_timer <= '0;
        WAIT: begin
          if (bus.div_done) begin
            r_respId  <= r_id;
            r_respQ   <= bus.div_q;
            r_respR   <= bus.div_r;
            r_respErr <= 1'b0;
          end else if (w_timeout) begin
            r_respId  <= r_id;
            r_respQ   <= '0;
            r_respR   <= '0;
            r_respErr <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        RESP: r_ptr <= (r_id == IDW'(N - 1)) ? '0 : r_id + IDW'(1);
        default: ;
      endcase
    end
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.div_go     = (r_state == ISSUE);
  assign bus.div_x      = (r_state == IDLE) ? '0 : r_x;
  assign bus.div_y      = (r_state == IDLE) ? '0 : r_y;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.ack        = (r_state == RESP) ? (N'(1) << r_respId) : '0;
  assign bus.resp_id    = r_respId;
  assign bus.resp_q     = r_respQ;
  assign bus.resp_r     = r_respR;
  assign bus.resp_err   = r_respErr;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler that shares one sequential integer divider between N requesters. Sits between the requesting blocks and the divider's go/done interface. It latches one request's operands, launches the divider, waits for completion or timeout, and returns quotient/remainder to the winning requester with a one-cycle acknowledge. Divide-by-zero is resolved locally without occupying the divider.

## Interface
- N, 4, number of requesters (2..8)
- W, 4, operand/result width; matches divider datapath width
- TIMEOUT, 64, max cycles in WAIT before forced error return (≥ 2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  per-requester request level
- req_x  in  N*W  dividends, requester i at [i*W +: W]
- req_y  in  N*W  divisors, same packing
- ack  out  N  one-hot, one-cycle completion pulse to the served requester
- resp_valid  out  1  high in the same cycle as ack
- resp_id  out  clog2(N)  index of the served requester
- resp_q  out  W  quotient
- resp_r  out  W  remainder
- resp_err  out  1  1 = divide-by-zero or timeout
- busy  out  1  high in every state except IDLE
- div_go  out  1  one-cycle start pulse to the divider
- div_x, div_y  out  W each  operands to the divider, held stable from ISSUE until response
- div_done  in  1  divider completion flag
- div_q, div_r  in  W each  divider results, valid while div_done = 1

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if req ≠ 0, grant the first set bit searching upward from ptr, wrapping at N. Latch id, x and y into internal registers.
  - If the latched y = 0: set q = all ones, r = x, err = 1, and go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: div_go = 1 for exactly one cycle; timer cleared; go to WAIT.
- WAIT: timer increments each cycle.
  - div_done = 1: capture div_q/div_r, err = 0, go to RESP.
  - Else if timer = TIMEOUT−1: q = 0, r = 0, err = 1, go to RESP.
  - div_done takes priority if it coincides with expiry.
- RESP: resp_valid = 1 and ack[id] = 1 for one cycle; resp_q/resp_r/resp_err/resp_id hold until the next RESP. Set ptr = (id+1) mod N; go to IDLE.
- Requester protocol:
  - Hold req and operands until ack.
  - A req still high in the cycle after ack is treated as a new request.
  - Operands are sampled only at grant; later changes are ignored.
  - Dropping req before ack is a protocol violation. The arbiter still completes and pulses ack.
- div_x/div_y are driven from the latched registers; they are 0 in IDLE.
- div_done is ignored outside WAIT.
- Fairness: with all N requesters continuously active, each is served exactly once per N transactions.

## Timing
- Reset values: state IDLE, ptr 0, timer 0, and ack, resp_valid, resp_id, resp_q, resp_r, resp_err, busy, div_go, div_x, div_y all 0.
- Reset asserted mid-transaction aborts immediately: no ack is issued and div_go stays low. The divider must be reset by the same rst_n domain.
- Grant is taken at the clock edge ending an IDLE cycle with req ≠ 0. busy rises at the next cycle.
- Normal path: grant edge → ISSUE (1 cycle) → WAIT (k cycles) → RESP (1 cycle).
  - If div_done is first seen in WAIT cycle k, ack occurs at cycle k+2 after the grant edge.
- Divide-by-zero path: ack in the cycle immediately following the grant edge.
- Timeout path: ack TIMEOUT+2 cycles after the grant edge.
- Back-to-back: after RESP, IDLE lasts at least one cycle, so the minimum spacing of div_go pulses is 4 cycles.
- Requests arriving while busy wait; no queueing beyond the req levels.

## Test plan
- Single request: req = 0001, x = 13, y = 4, divider model done after 9 cycles → ack = 0001, resp_q = 3, resp_r = 1, resp_err = 0, resp_id = 0, exactly one div_go pulse.
- Round-robin: req = 1111 held, operands (i+9, 2) per requester i → ack order 0, 1, 2, 3, 0. Check wrap from ptr = 3 to 0 and correct per-id results.
- Divide-by-zero: req = 0100, x = 7, y = 0 → ack = 0100 one cycle after grant, resp_q = 15, resp_r = 7, resp_err = 1, div_go never asserted.
- Timeout: divider model never asserts done, TIMEOUT = 64 → ack 66 cycles after grant, resp_err = 1, resp_q = 0, resp_r = 0, then the next request is served normally.
- Simultaneous done and expiry: done asserted in WAIT cycle 64 → results captured, resp_err = 0.
- Reset mid-WAIT: drop rst_n during WAIT → all outputs 0 immediately, no ack. After release, req = 0010 is granted first (ptr = 0 search) and completes correctly.
